// File: rtl/wb_stage_reg_pkg.sv
// Shared constants and types for the writeback stage register.
// Extends the classic pipeline defines with stage-mode encoding.
package wb_stage_reg_pkg;

    localparam logic        RST_ACTIVE   = 1'b0;
    localparam logic        STOP         = 1'b1;
    localparam logic        NOSTOP       = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'h00;
    localparam int          STALL_W_DEF  = 6;

    typedef enum logic [1:0] {
        MODE_ADVANCE,
        MODE_HOLD,
        MODE_BUBBLE,
        MODE_FLUSH
    } stage_mode_e;

endpackage

// File: rtl/wb_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import wb_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register with multi-lane GPR writes, HI/LO lane,
// flush/bubble/hold handling, r0 suppression and same-cycle WAW collapse.
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LANES   = 1,
    parameter int STALL_W = STALL_W_DEF,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      cnt_clr,
    input  logic [LANES-1:0]          in_wreg,
    input  logic [LANES*ADDR_W-1:0]   in_wd,
    input  logic [LANES*DATA_W-1:0]   in_wdata,
    input  logic                      in_whilo,
    input  logic [DATA_W-1:0]         in_hi,
    input  logic [DATA_W-1:0]         in_lo,
    output logic [LANES-1:0]          out_wreg,
    output logic [LANES*ADDR_W-1:0]   out_wd,
    output logic [LANES*DATA_W-1:0]   out_wdata,
    output logic                      out_whilo,
    output logic [DATA_W-1:0]         out_hi,
    output logic [DATA_W-1:0]         out_lo,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          hold_cnt
);

    stage_mode_e mode;
    logic [LANES-1:0] wreg_filt;

    // Only our own and the downstream stall bits matter here.
    logic stall_unused;
    assign stall_unused = ^stall;

    always_comb begin
        if (flush) begin
            mode = MODE_FLUSH;
        end else if (stall[STAGE] == STOP) begin
            mode = (stall[STAGE+1] == STOP) ? MODE_HOLD : MODE_BUBBLE;
        end else begin
            mode = MODE_ADVANCE;
        end
    end

    // A lane is dropped if it targets r0 or a higher lane writes the same register.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic shadowed;
        always_comb begin
            shadowed = 1'b0;
            for (int j = i + 1; j < LANES; j++) begin
                if (in_wreg[j] && (in_wd[j*ADDR_W +: ADDR_W] == in_wd[i*ADDR_W +: ADDR_W])) begin
                    shadowed = 1'b1;
                end
            end
        end
        assign wreg_filt[i] = in_wreg[i]
                            && (in_wd[i*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR))
                            && !shadowed;
    end

    logic [LANES-1:0]        wreg_q,  wreg_d;
    logic [LANES*ADDR_W-1:0] wd_q,    wd_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic                    whilo_q, whilo_d;
    logic [DATA_W-1:0]       hi_q,    hi_d;
    logic [DATA_W-1:0]       lo_q,    lo_d;

    always_comb begin
        wreg_d  = wreg_q;
        wd_d    = wd_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (mode)
            MODE_FLUSH, MODE_BUBBLE: begin
                wreg_d  = '0;
                wd_d    = '0;
                wdata_d = '0;
                whilo_d = 1'b0;
                hi_d    = DATA_W'(ZERO_WORD);
                lo_d    = DATA_W'(ZERO_WORD);
            end
            MODE_HOLD: begin
            end
            default: begin
                wreg_d  = wreg_filt;
                wd_d    = in_wd;
                wdata_d = in_wdata;
                whilo_d = in_whilo;
                hi_d    = in_hi;
                lo_d    = in_lo;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wreg_q  <= '0;
            wd_q    <= '0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign out_wreg  = wreg_q;
    assign out_wd    = wd_q;
    assign out_wdata = wdata_q;
    assign out_whilo = whilo_q;
    assign out_hi    = hi_q;
    assign out_lo    = lo_q;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (mode == MODE_BUBBLE),
        .cnt (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (mode == MODE_HOLD),
        .cnt (hold_cnt)
    );

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised pipeline stage register for the MEM→WB boundary (and any later stage boundary using the same 6-bit stall vector). It generalises the single-lane MEM/WB register to `LANES` parallel GPR write lanes plus one HI/LO lane. It adds a synchronous flush, suppression of writes to register 0, and collapse of same-cycle write-after-write between lanes. Saturating bubble/hold counters feed the performance-monitor block.

## Interface
- `DATA_W`, 32, GPR/HI/LO data width
- `ADDR_W`, 5, GPR address width
- `LANES`, 1, number of parallel GPR write lanes (1..4)
- `STALL_W`, 6, width of the pipeline stall vector
- `STAGE`, 4, index of this register's own stall bit; the downstream bit is `STAGE+1`; `STAGE <= STALL_W-2`
- `CNT_W`, 16, counter width
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — reset, asynchronous, active-low (asserted at 0)
- `stall` in STALL_W — pipeline stall vector, 1 = Stop
- `flush` in 1 — synchronous flush, kills the captured entry
- `cnt_clr` in 1 — synchronous clear of both counters
- `in_wreg` in LANES — per-lane GPR write enable
- `in_wd` in LANES*ADDR_W — per-lane destination address, lane i at bits [i*ADDR_W +: ADDR_W]
- `in_wdata` in LANES*DATA_W — per-lane write data
- `in_whilo` in 1 — HI/LO write enable
- `in_hi`, `in_lo` in DATA_W — HI/LO data
- `out_wreg`, `out_wd`, `out_wdata`, `out_whilo`, `out_hi`, `out_lo` out — registered copies, same widths
- `bubble_cnt` out CNT_W — bubbles inserted
- `hold_cnt` out CNT_W — cycles held

## Operation
- Per-edge priority: reset > flush > bubble > hold > advance.
- Reset (`rst`=0, async): all outputs 0, including addresses, data, enables and both counters.
- Flush (`flush`=1): all `out_*` set to 0. Counters are not incremented.
- Bubble (`stall[STAGE]`=1, `stall[STAGE+1]`=0): all `out_*` set to 0. `bubble_cnt` increments.
- Hold (`stall[STAGE]`=1, `stall[STAGE+1]`=1): all `out_*` keep their value. `hold_cnt` increments.
- Advance (`stall[STAGE]`=0): capture the filtered inputs.
- Input filter on advance, per lane i:
  - `out_wreg[i]` = `in_wreg[i]` AND `in_wd[i]`≠0.
  - If a higher lane j>i has `in_wreg[j]`=1 with the same nonzero address, `out_wreg[i]`=0 (highest lane wins).
  - Address and data are captured unmodified even when the enable is filtered.
- HI/LO lane: no filtering; captured as given.
- Counters: saturate at all-ones. `cnt_clr`=1 forces 0 that cycle and overrides any increment.
- `stall[STAGE]`=0 with `stall[STAGE+1]`=1 is legal. The stage advances; downstream stalling is the controller's responsibility.

## Timing
- Latency: 1 cycle input→output on advance.
- No combinational path from any input to any output.
- Reset deassertion: first capture on the first rising edge with `rst`=1.
- Reset asserted mid-hold: contents are lost and outputs read 0 immediately, without waiting for an edge.
- Flush and bubble in the same cycle: flush wins, so `bubble_cnt` is unchanged.
- Flush during hold: outputs cleared, so hold does not preserve the entry.
- Counter at all-ones with an increment condition: stays at all-ones.

## Structure
- Shared package (extend `defines`):
  - `RST_ACTIVE` = 1'b0
  - `STOP`/`NOSTOP`
  - `ZERO_WORD`
  - `NOP_REG_ADDR`
  - the default stall vector width
- Sub-module `sat_counter` (params `CNT_W`; ports `clk`, `rst`, `clr`, `inc`, `cnt`), instantiated twice.
- Lane WAW filter: a generate loop inside `wb_stage_reg`, not a separate module.

## Test plan
- Reset: hold `rst`=0 mid-advance with inputs nonzero → all outputs 0 asynchronously; release; next edge captures `in_wd`=5, `in_wdata`=0xDEADBEEF, `in_wreg`=1 → `out_*` match.
- Bubble vs hold: `stall`=6'b010000 for 1 cycle → outputs 0, `bubble_cnt`=1. `stall`=6'b110000 for 3 cycles → outputs unchanged, `hold_cnt`=3.
- Flush priority: `flush`=1 with `stall`=6'b010000 → outputs 0, `bubble_cnt` unchanged.
- LANES=2 WAW: lane0 wd=7 data=0x1, lane1 wd=7 data=0x2, both wreg=1 → `out_wreg`=2'b10. Same with lane0 wd=0 and lane1 wd=3 → `out_wreg`=2'b10.
- Register-0 suppression: LANES=1, wd=0, wreg=1 → `out_wreg`=0, `out_wd`=0.
- Counter saturation: CNT_W=4, 20 consecutive bubbles → `bubble_cnt`=15. Then `cnt_clr`=1 during a bubble → `bubble_cnt`=0.
